// File: rtl/add_mul_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_mul_mix_pkg
// Purpose  : Shared widths and the round-robin pick helper for the
//            add-multiply arbiter and its combinational core.
// Contents : OPND_W, SUM_W, PROD_W, RES_W datapath widths
//            MAX_REQ / IDX_W  upper bound on requester count and index width
//            rr_pick()        first valid index at or after ptr, wrapping
// Revision : 1.0  initial release
// ============================================================================
package add_mul_mix_pkg;

    localparam int OPND_W  = 4;   // each operand a/b/c/d
    localparam int SUM_W   = 5;   // a+b or c+d without loss
    localparam int PROD_W  = 10;  // full (a+b)*(c+d)
    localparam int RES_W   = 8;   // delivered result, product mod 256

    localparam int MAX_REQ = 16;  // largest supported requester count
    localparam int IDX_W   = 4;   // index width able to address MAX_REQ

    // Round-robin pick: search from ptr upward, wrapping modulo num, and
    // return the first index whose valid bit is set. Returns 0 when nothing
    // is valid; callers must qualify the result with |valid.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        num
    );
        logic        found;
        int unsigned pos;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = (32'(ptr) + k) % num;
            if (!found && (k < num) && valid[pos[IDX_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = pos[IDX_W-1:0];
            end
        end
    endfunction

endpackage : add_mul_mix_pkg
`default_nettype wire

// File: rtl/add_mul_mix_core.sv
`default_nettype none
// ============================================================================
// Module   : add_mul_mix_core
// Purpose  : Purely combinational add-multiply datapath,
//            product = (a + b) * (c + d), kept at full 10-bit width.
//            Drop-in equivalent of the gate-level 4-bit datapath netlist.
// Ports    : a, b, c, d  in  OPND_W  unsigned operands
//            product     out PROD_W  full-width unsigned product
// Revision : 1.0  initial release
// ============================================================================
module add_mul_mix_core
    import add_mul_mix_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [OPND_W-1:0] c,
    input  logic [OPND_W-1:0] d,
    output logic [PROD_W-1:0] product
);

    logic [SUM_W-1:0] w_sum_ab;
    logic [SUM_W-1:0] w_sum_cd;

    // Zero-extend before adding so the carry out lands in the sum MSB.
    assign w_sum_ab = {1'b0, a} + {1'b0, b};
    assign w_sum_cd = {1'b0, c} + {1'b0, d};

    // 5x5 unsigned product fits exactly in 10 bits (max 30*30 = 900).
    assign product  = {{(PROD_W-SUM_W){1'b0}}, w_sum_ab}
                    * {{(PROD_W-SUM_W){1'b0}}, w_sum_cd};

endmodule : add_mul_mix_core
`default_nettype wire

// File: rtl/add_mul_mix_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : add_mul_mix_arbiter
// Purpose  : Round-robin arbiter sharing one add-multiply core between
//            NUM_REQ requesters. The winner's result is captured in a
//            single-entry register tagged with the requester ID and offered
//            downstream under valid/ready.
// Ports    : clk, rst               clock, synchronous active-high reset
//            req_valid/req_ready    per-requester handshake (ready one-hot/0)
//            req_a/b/c/d            packed operands, requester i at [4i+3:4i]
//            res_valid/res_ready    result handshake
//            res_data               (a+b)*(c+d) mod 256
//            res_id                 index of the producing requester
//            res_ovf                (only with ADD_MUL_MIX_ARB_OVF_EN) set when
//                                   product[9:8] != 0
// Config   : `define ADD_MUL_MIX_ARB_OVF_EN adds the res_ovf output.
// Revision : 1.0  initial release
// ============================================================================
module add_mul_mix_arbiter
    import add_mul_mix_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [OPND_W*NUM_REQ-1:0] req_a,
    input  logic [OPND_W*NUM_REQ-1:0] req_b,
    input  logic [OPND_W*NUM_REQ-1:0] req_c,
    input  logic [OPND_W*NUM_REQ-1:0] req_d,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic [ID_W-1:0]          res_id
`ifdef ADD_MUL_MIX_ARB_OVF_EN
    ,
    output logic                     res_ovf
`endif
);

    // ------------------------------------------------------------------
    // State: the result register and the round-robin pointer
    // ------------------------------------------------------------------
    logic              r_res_valid;
    logic [RES_W-1:0]  r_res_data;
    logic [ID_W-1:0]   r_res_id;
    logic [ID_W-1:0]   r_rr_ptr;
`ifdef ADD_MUL_MIX_ARB_OVF_EN
    logic              r_res_ovf;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [MAX_REQ-1:0] w_valid_ext;
    logic [IDX_W-1:0]   w_pick;
    logic [ID_W-1:0]    w_win;
    logic               w_any;
    logic               w_slot_free;
    logic               w_accept;
    logic [ID_W-1:0]    w_ptr_next;

    // Widen the valid vector to the helper's fixed width; unused upper
    // bits stay zero so they can never be picked.
    always_comb begin
        w_valid_ext = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_valid_ext[i] = req_valid[i];
        end
    end

    assign w_pick      = rr_pick(w_valid_ext, IDX_W'(r_rr_ptr), NUM_REQ);
    assign w_win       = ID_W'(w_pick);
    assign w_any       = |req_valid;

    // The single register can take a new result when it is empty or is
    // being drained this same cycle, which gives back-to-back throughput.
    assign w_slot_free = !r_res_valid || res_ready;

    // Reset gates acceptance so req_ready reads 0 throughout reset.
    assign w_accept    = w_any && w_slot_free && !rst;

    assign w_ptr_next  = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_accept && (w_win == ID_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand select and shared datapath
    // ------------------------------------------------------------------
    logic [OPND_W-1:0] w_a;
    logic [OPND_W-1:0] w_b;
    logic [OPND_W-1:0] w_c;
    logic [OPND_W-1:0] w_d;
    logic [PROD_W-1:0] w_product;

    always_comb begin
        w_a = '0;
        w_b = '0;
        w_c = '0;
        w_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_a = req_a[OPND_W*i +: OPND_W];
                w_b = req_b[OPND_W*i +: OPND_W];
                w_c = req_c[OPND_W*i +: OPND_W];
                w_d = req_d[OPND_W*i +: OPND_W];
            end
        end
    end

    add_mul_mix_core u_core (
        .a       (w_a),
        .b       (w_b),
        .c       (w_c),
        .d       (w_d),
        .product (w_product)
    );

    // ------------------------------------------------------------------
    // Result register and pointer update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            // Replaces any result drained this cycle: no bubble.
            r_res_valid <= 1'b1;
            r_res_data  <= RES_W'(w_product);
            r_res_id    <= w_win;
            r_rr_ptr    <= w_ptr_next;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef ADD_MUL_MIX_ARB_OVF_EN
    // Truncation flag travels with the data and is held the same way.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_ovf <= 1'b0;
        end else if (w_accept) begin
            r_res_ovf <= |w_product[PROD_W-1:RES_W];
        end
    end

    assign res_ovf = r_res_ovf;
`endif

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;

endmodule : add_mul_mix_arbiter
`default_nettype wire

// File: tb/tb_add_mul_mix_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_mul_mix_arbiter
// Purpose  : Directed self-checking bench for add_mul_mix_arbiter with
//            NUM_REQ = 4 and hand-computed expected results.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_add_mul_mix_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0] req_c;
    logic [4*NUM_REQ-1:0] req_d;
    logic                 res_valid;
    logic                 res_ready;
    logic [7:0]           res_data;
    logic [ID_W-1:0]      res_id;
`ifdef ADD_MUL_MIX_ARB_OVF_EN
    logic                 res_ovf;
`endif

    int n_cmp;
    int n_err;

    add_mul_mix_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_d     (req_d),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
`ifdef ADD_MUL_MIX_ARB_OVF_EN
        ,
        .res_ovf   (res_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
        req_c[4*i +: 4] = c;
        req_d[4*i +: 4] = d;
    endtask

    // (i+1)*(2+i) for requester i loaded with a=i b=1 c=2 d=i
    logic [7:0] rr_exp [4];
    logic [1:0] rr_id;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rr_exp[0] = 8'd2;
        rr_exp[1] = 8'd6;
        rr_exp[2] = 8'd12;
        rr_exp[3] = 8'd20;

        rst       = 1'b1;
        req_valid = 4'b0100;
        res_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        step();
        step();

        // Reset state
        check("rst_ready",     32'(req_ready), 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data",  32'(res_data),  32'h0);
        check("rst_res_id",    32'(res_id),    32'h0);
`ifdef ADD_MUL_MIX_ARB_OVF_EN
        check("rst_res_ovf",   32'(res_ovf),   32'h0);
`endif
        rst       = 1'b0;
        req_valid = 4'b0000;
        step();

        // Single request: 5*5 = 25
        set_req(0, 4'd3, 4'd2, 4'd1, 4'd4);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #1;
        check("single_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_data",  32'(res_data),  32'd25);
        check("single_id",    32'(res_id),    32'd0);

        // Truncation: 30*30 = 900, 900 mod 256 = 132
        set_req(0, 4'd15, 4'd15, 4'd15, 4'd15);
        req_valid = 4'b0001;
        #1;
        check("trunc_ready", 32'(req_ready), 32'b0001);
        step();
        check("trunc_data", 32'(res_data), 32'd132);
`ifdef ADD_MUL_MIX_ARB_OVF_EN
        check("trunc_ovf",  32'(res_ovf),  32'd1);
`endif
        set_req(0, 4'd1, 4'd0, 4'd1, 4'd0);
        step();
        req_valid = 4'b0000;
        check("small_data", 32'(res_data), 32'd1);
`ifdef ADD_MUL_MIX_ARB_OVF_EN
        check("small_ovf",  32'(res_ovf),  32'd0);
`endif
        step();
        check("drain_valid", 32'(res_valid), 32'd0);

        // Pointer is 1 here; reset must bring it back to 0 so the
        // round-robin sequence starts at requester 0.
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Round-robin with all four valid: ids 0,1,2,3,0,1 back to back
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 4'(i), 4'd1, 4'd2, 4'(i));
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            rr_id = 2'(k % 4);
            check("rr_valid", 32'(res_valid), 32'd1);
            check("rr_id",    32'(res_id),    32'(rr_id));
            check("rr_data",  32'(res_data),  32'(rr_exp[rr_id]));
        end

        // Backpressure: register holds id1/6, pointer stays at 2
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", 32'(req_ready), 32'h0);
            step();
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_id",    32'(res_id),    32'd1);
            check("bp_data",  32'(res_data),  32'd6);
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        check("bp_next_valid", 32'(res_valid), 32'd1);
        check("bp_next_id",    32'(res_id),    32'd2);
        check("bp_next_data",  32'(res_data),  32'd12);

        // Wrap and skip: pointer 3, only req1 valid -> winner 1, pointer 2
        req_valid = 4'b0010;
        #1;
        check("wrap_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1111;
        check("wrap_id",   32'(res_id),   32'd1);
        check("wrap_data", 32'(res_data), 32'd6);
        #1;
        check("wrap_ptr_ready", 32'(req_ready), 32'b0100);

        // Reset mid-stream with a held result and req2 pending
        req_valid = 4'b0100;
        res_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("midrst_ready_in_rst", 32'(req_ready), 32'h0);
        step();
        check("midrst_valid", 32'(res_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        rst       = 1'b0;
        res_ready = 1'b1;
        #1;
        check("postrst_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        check("postrst_valid", 32'(res_valid), 32'd1);
        check("postrst_id",    32'(res_id),    32'd2);
        check("postrst_data",  32'(res_data),  32'd12);
        step();
        check("idle_valid", 32'(res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: the directed sequence is short; never let it hang.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_add_mul_mix_arbiter
`default_nettype wire
